// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types and helpers for the multi-cycle shift sequencer
package shift_pkg;

   typedef enum logic [1:0] {
      SLL = 2'b00,
      SRL = 2'b01,
      SRA = 2'b11
   } shift_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } shift_state_t;

   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational shifter moving an XLEN word by 0..STEP bits
import shift_pkg::*;

module shift_step #(
   parameter int XLEN = 64,
   parameter int STEP = 8,
   localparam int SW = $clog2(STEP + 1)
) (
   input  logic [XLEN-1:0] dataIn,
   input  logic [1:0]      op,
   input  logic [SW-1:0]   amt,
   output logic [XLEN-1:0] dataOut
);

   // op 2'b10 is unassigned and falls through to a logical right shift
   always_comb begin
      case (op)
         SLL:     dataOut = dataIn << amt;
         SRA:     dataOut = XLEN'($signed(dataIn) >>> amt);
         default: dataOut = dataIn >> amt;
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - sequences shift_step over several cycles for RV64 SLL/SRL/SRA(W)
import shift_pkg::*;

module shift_sequencer #(
   parameter int XLEN = 64,
   parameter int STEP = 8,
   localparam int AW = $clog2(XLEN),
   localparam int SW = $clog2(STEP + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      in_op,
   input  logic            in_word,
   input  logic [XLEN-1:0] in_data,
   input  logic [AW-1:0]   in_amt,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_data,
   output logic            busy
);

   shift_state_t    state;
   logic [1:0]      opReg;
   logic            wordReg;
   logic [XLEN-1:0] acc;
   logic [AW-1:0]   rem;

   logic [AW-1:0]   amtEff;
   logic [XLEN-1:0] loadVal;
   logic [SW-1:0]   stepAmt;
   logic [XLEN-1:0] stepOut;

   function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
      return XLEN'($signed(v[31:0]));
   endfunction

   assign in_ready = (state == IDLE) && !reset;
   assign busy     = (state != IDLE);

   // word ops shift only the low 32 bits; the upper half is prepared so right shifts fill correctly
   always_comb begin
      amtEff  = in_word ? AW'(in_amt[4:0]) : in_amt;
      loadVal = in_data;
      if (in_word) begin
         if (in_op == SRA)
            loadVal = sext32(in_data);
         else if (in_op != SLL)
            loadVal = XLEN'(in_data[31:0]);
      end
   end

   always_comb begin
      if (int'(rem) >= STEP)
         stepAmt = SW'(STEP);
      else
         stepAmt = SW'(rem);
   end

   shift_step #(.XLEN(XLEN), .STEP(STEP)) uStep (
      .dataIn  (acc),
      .op      (opReg),
      .amt     (stepAmt),
      .dataOut (stepOut)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         opReg     <= 2'b00;
         wordReg   <= 1'b0;
         acc       <= '0;
         rem       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  opReg   <= in_op;
                  wordReg <= in_word;
                  acc     <= loadVal;
                  rem     <= amtEff;
                  if (amtEff == '0) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     out_data  <= in_word ? sext32(loadVal) : loadVal;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               acc <= stepOut;
               rem <= rem - AW'(stepAmt);
               if (rem == AW'(stepAmt)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  out_data  <= wordReg ? sext32(stepOut) : stepOut;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
